// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wwp_fetch_defs (package)
// Brief   : Shared fetch-stage state encodings and width/halt-word defaults.
// Revision: 1.0 - initial release
// ============================================================================
package wwp_fetch_defs;

    localparam int c_ADDR_WIDTH  = 32;
    localparam int c_INSTR_WIDTH = 32;
    localparam logic [31:0] c_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_t;

endpackage : wwp_fetch_defs
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_if
// Brief   : Fetch-stage bus: control inputs, memory port and IF/ID outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface instr_fetch_if
    import wwp_fetch_defs::*;
#(
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int INSTR_WIDTH = c_INSTR_WIDTH
);

    logic                     stall;
    logic                     branch_taken;
    logic [0:ADDR_WIDTH-1]    branch_target;
    logic [0:INSTR_WIDTH-1]   instruction;
    logic [0:ADDR_WIDTH-1]    instr_mem_addr;
    logic                     instr_mem_en;
    logic [0:INSTR_WIDTH-1]   if_instruction;
    logic [0:ADDR_WIDTH-1]    if_pc;
    logic                     if_valid;
    logic                     halted;

    // The fetch stage is the master: it owns the address and the IF/ID outputs.
    modport master (
        input  stall, branch_taken, branch_target, instruction,
        output instr_mem_addr, instr_mem_en, if_instruction, if_pc, if_valid, halted
    );

    modport slave (
        output stall, branch_taken, branch_target, instruction,
        input  instr_mem_addr, instr_mem_en, if_instruction, if_pc, if_valid, halted
    );

endinterface : instr_fetch_if
`default_nettype wire

// File: rtl/instr_fetch_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register with load, hold and squash controls.
// Revision: 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    input  wire logic                   i_load,
    input  wire logic                   i_squash,
    input  wire logic [0:INSTR_WIDTH-1] i_instr,
    input  wire logic [0:ADDR_WIDTH-1]  i_pc,
    output logic      [0:INSTR_WIDTH-1] o_instr,
    output logic      [0:ADDR_WIDTH-1]  o_pc,
    output logic                        o_valid
);

    logic [0:INSTR_WIDTH-1] r_instr;
    logic [0:ADDR_WIDTH-1]  r_pc;
    logic                   r_valid;

    // Squash only drops the valid bit; the stale payload is left in place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_squash) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Brief   : Fetch stage: PC, next-PC mux, fetch FSM and IF/ID register.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch
    import wwp_fetch_defs::*;
#(
    parameter int                     ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int                     INSTR_WIDTH = c_INSTR_WIDTH,
    parameter int unsigned            START_ADDR  = 0,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = INSTR_WIDTH'(c_HALT_WORD)
) (
    input  wire logic     clock,
    input  wire logic     reset,
    instr_fetch_if.master bus
);

    fetch_state_t          r_state;
    logic [0:ADDR_WIDTH-1] r_pc;
    logic                  w_is_halt;
    logic                  w_load;
    logic                  w_squash;

    assign w_is_halt = (bus.instruction == HALT_WORD);

    // Branch beats stall, stall beats the halt check, halt beats a normal load.
    always_comb begin
        w_load   = 1'b0;
        w_squash = 1'b0;
        if (r_state == ST_FETCH) begin
            if (bus.branch_taken) begin
                w_squash = 1'b1;
            end else if (!bus.stall) begin
                if (w_is_halt) begin
                    w_squash = 1'b1;
                end else begin
                    w_load = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= ADDR_WIDTH'(START_ADDR);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    if (bus.branch_taken) begin
                        r_pc <= bus.branch_target;
                    end
                end
                ST_FETCH: begin
                    if (bus.branch_taken) begin
                        r_pc <= bus.branch_target;
                    end else if (!bus.stall) begin
                        if (w_is_halt) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_pc <= r_pc + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_mem_addr = r_pc;
    assign bus.instr_mem_en   = (r_state == ST_FETCH);
    assign bus.halted         = (r_state == ST_HALT);

    if_id_reg #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id_reg (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_squash (w_squash),
        .i_instr  (bus.instruction),
        .i_pc     (r_pc),
        .o_instr  (bus.if_instruction),
        .o_pc     (bus.if_pc),
        .o_valid  (bus.if_valid)
    );

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Directed vector bench for instr_fetch, plus a 4-bit wrap instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        en;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        halted;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    vec_t vq[$];
    logic [31:0] mem [0:63];

    instr_fetch_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();
    instr_fetch_if #(.ADDR_WIDTH(4),  .INSTR_WIDTH(32)) bus_w ();

    instr_fetch #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .START_ADDR  (0),
        .HALT_WORD   (32'hFFFF_FFFF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    instr_fetch #(
        .ADDR_WIDTH  (4),
        .INSTR_WIDTH (32),
        .START_ADDR  (14),
        .HALT_WORD   (32'hFFFF_FFFF)
    ) dut_wrap (
        .clock (clock),
        .reset (reset),
        .bus   (bus_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational instruction memories.
    always_comb bus.instruction = (bus.instr_mem_addr < 32'd64) ?
                                  mem[bus.instr_mem_addr[26:31]] : 32'h0;
    always_comb bus_w.instruction = 32'hB000_0000 | 32'(bus_w.instr_mem_addr);

    assign bus_w.stall         = 1'b0;
    assign bus_w.branch_taken  = 1'b0;
    assign bus_w.branch_target = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [31:0] addr, input logic en,
                              input logic valid, input logic [31:0] pc,
                              input logic [31:0] instr, input logic halted);
        check({tag, " addr"},   32'(bus.instr_mem_addr), addr);
        check({tag, " en"},     32'(bus.instr_mem_en),   32'(en));
        check({tag, " valid"},  32'(bus.if_valid),       32'(valid));
        check({tag, " if_pc"},  32'(bus.if_pc),          pc);
        check({tag, " instr"},  32'(bus.if_instruction), instr);
        check({tag, " halted"}, 32'(bus.halted),         32'(halted));
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] t,
                       input logic [31:0] a, input logic e, input logic v,
                       input logic [31:0] p, input logic [31:0] i, input logic h);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t; x.addr = a; x.en = e;
        x.valid = v; x.pc = p; x.instr = i; x.halted = h;
        vq.push_back(x);
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t);
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.branch_target = t;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[5] = 32'hFFFF_FFFF;

        //   stall br tgt   addr en val pc  instr         halted
        add(0, 0, 0,   0,  1, 0, 0,  32'h0,         0); // IDLE -> FETCH
        add(0, 0, 0,   1,  1, 1, 0,  32'hA000_0000, 0);
        add(0, 0, 0,   2,  1, 1, 1,  32'hA000_0001, 0);
        add(1, 0, 0,   2,  1, 1, 1,  32'hA000_0001, 0); // stall x3 at PC=2
        add(1, 0, 0,   2,  1, 1, 1,  32'hA000_0001, 0);
        add(1, 0, 0,   2,  1, 1, 1,  32'hA000_0001, 0);
        add(0, 0, 0,   3,  1, 1, 2,  32'hA000_0002, 0);
        add(0, 1, 10,  10, 1, 0, 2,  32'hA000_0002, 0); // branch at PC=3
        add(0, 0, 0,   11, 1, 1, 10, 32'hA000_000A, 0);
        add(1, 1, 20,  20, 1, 0, 10, 32'hA000_000A, 0); // branch + stall
        add(1, 0, 0,   20, 1, 0, 10, 32'hA000_000A, 0);
        add(0, 0, 0,   21, 1, 1, 20, 32'hA000_0014, 0);
        add(0, 1, 4,   4,  1, 0, 20, 32'hA000_0014, 0);
        add(0, 0, 0,   5,  1, 1, 4,  32'hA000_0004, 0);
        add(0, 0, 0,   5,  0, 0, 4,  32'hA000_0004, 1); // halt word at 5
        add(0, 1, 0,   5,  0, 0, 4,  32'hA000_0004, 1); // branch ignored
        add(1, 0, 0,   5,  0, 0, 4,  32'hA000_0004, 1);

        reset = 1'b0;
        drive(0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check_main("reset", 0, 0, 0, 0, 32'h0, 0);
        reset = 1'b1;
        #1;
        check_main("idle", 0, 0, 0, 0, 32'h0, 0);

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].stall, vq[k].br, vq[k].tgt);
            @(posedge clock);
            #1;
            check_main($sformatf("vec%0d", k), vq[k].addr, vq[k].en, vq[k].valid,
                       vq[k].pc, vq[k].instr, vq[k].halted);
        end

        // Asynchronous reset out of HALT, away from any clock edge.
        drive(0, 0, 0);
        #3 reset = 1'b0;
        #1;
        check_main("async_reset", 0, 0, 0, 0, 32'h0, 0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Branch from IDLE, then branch on the halt-word cycle.
        drive(0, 1, 5);
        @(posedge clock); #1;
        check_main("idle_branch", 5, 1, 0, 0, 32'h0, 0);
        drive(0, 1, 7);
        @(posedge clock); #1;
        check_main("branch_on_halt", 7, 1, 0, 0, 32'h0, 0);
        drive(0, 0, 0);
        @(posedge clock); #1;
        check_main("after_branch", 8, 1, 1, 7, 32'hA000_0007, 0);

        // Wrap-around on the 4-bit instance.
        #2 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        check("wrap idle addr", 32'(bus_w.instr_mem_addr), 32'd14);
        check("wrap idle en",   32'(bus_w.instr_mem_en),   32'd0);
        @(posedge clock); #1;
        check("wrap e1 addr",  32'(bus_w.instr_mem_addr), 32'd14);
        check("wrap e1 valid", 32'(bus_w.if_valid),       32'd0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_pc;
            exp_pc = (k == 0) ? 32'd14 : (k == 1) ? 32'd15 : (k == 2) ? 32'd0 : 32'd1;
            @(posedge clock); #1;
            check($sformatf("wrap%0d if_pc", k), 32'(bus_w.if_pc), exp_pc);
            check($sformatf("wrap%0d valid", k), 32'(bus_w.if_valid), 32'd1);
            check($sformatf("wrap%0d instr", k), 32'(bus_w.if_instruction),
                  32'hB000_0000 | exp_pc);
            check($sformatf("wrap%0d addr", k), 32'(bus_w.instr_mem_addr),
                  (exp_pc + 32'd1) & 32'hF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the Troy WideWord Processor, directly upstream of `instr_mem`. It owns the program counter and drives the memory's address and enable. It captures the returned 32-bit instruction into the IF/ID pipeline register for decode. It supports stall, branch redirect with squash, and halt on a reserved instruction word.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC and memory address width; word-addressed.
- `INSTR_WIDTH`, 32: instruction width.
- `START_ADDR`, 0: PC value loaded at reset.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that halts fetch.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low.
- `stall`  in  1: hold PC and IF/ID (decode back-pressure).
- `branch_taken`  in  1: redirect request.
- `branch_target`  in  [0:ADDR_WIDTH-1]: redirect address.
- `instruction`  in  [0:INSTR_WIDTH-1]: from `instr_mem`, combinational read of the current address.
- `instr_mem_addr`  out  [0:ADDR_WIDTH-1]: equals the PC register.
- `instr_mem_en`  out  1: memory enable.
- `if_instruction`  out  [0:INSTR_WIDTH-1]: IF/ID instruction.
- `if_pc`  out  [0:ADDR_WIDTH-1]: PC of `if_instruction`.
- `if_valid`  out  1: IF/ID holds a real instruction.
- `halted`  out  1: fetch stopped.

## Operation
- **States:** IDLE, FETCH, HALT.
- **Reset (asynchronous, `reset`=0):**
  - State = IDLE, PC = `START_ADDR`.
  - `if_instruction`=0, `if_pc`=0, `if_valid`=0, `halted`=0, `instr_mem_en`=0.
- **IDLE:** goes to FETCH on the first edge after reset is released. `instr_mem_en`=0. A branch in IDLE loads `branch_target` into the PC.
- **FETCH:** `instr_mem_en`=1. Each edge applies the first matching rule:
  1. `branch_taken`=1, regardless of `stall`: PC ← `branch_target`, `if_valid` ← 0 (wrong-path squash). `if_instruction` and `if_pc` hold.
  2. `stall`=1: PC, `if_instruction`, `if_pc` and `if_valid` all hold.
  3. `instruction` == `HALT_WORD`: `if_valid` ← 0, PC holds, state ← HALT, `halted` ← 1.
  4. Otherwise: `if_instruction` ← `instruction`, `if_pc` ← PC, `if_valid` ← 1, PC ← PC+1.
- **HALT:** `instr_mem_en`=0, `halted`=1, all registers frozen. `branch_taken` and `stall` are ignored. Only reset exits HALT.
- **Arithmetic:** PC+1 is computed modulo 2^`ADDR_WIDTH`; the all-ones address wraps to 0 with no flag.
- **Enable decode:** `instr_mem_en` and `halted` are decoded from the state register only (glitch-free, no input dependence).

## Timing
- Fetch latency is one cycle. The address is presented in cycle n; the instruction appears on `if_instruction` with `if_valid`=1 after edge n+1.
- Throughput is one instruction per cycle while `stall`=0 and no branch.
- **Branch penalty:** one bubble. The instruction at the old PC is discarded, and the target instruction is valid after the second edge following the branch.
- **Branch and stall together:** the branch wins. The redirect and squash occur, and the stall takes effect from the next cycle.
- **Branch on the halt-word cycle:** the branch wins and no halt occurs.
- **Reset mid-operation:** all outputs go to their reset values immediately, without waiting for `clock`.

## Structure
- Shared package/header `wwp_fetch_defs`:
  - state encodings (IDLE=2'b00, FETCH=2'b01, HALT=2'b10);
  - default `HALT_WORD`;
  - `ADDR_WIDTH` and `INSTR_WIDTH` defaults, reused by `instr_mem` and decode.
- One sub-module, `if_id_reg`: the IF/ID pipeline register, holding `if_instruction`, `if_pc` and `if_valid`, with load/hold/squash controls and async active-low reset.
- The PC register, next-PC mux and state machine stay in `instr_fetch`.

## Test plan
- **Reset:** assert `reset`=0 mid-cycle → all outputs at reset values immediately. Release → one IDLE cycle with `instr_mem_en`=0, then `instr_mem_addr`=0 and `instr_mem_en`=1.
- **Sequential fetch:** memory preloaded with words A0..A3 at addresses 0..3 → `if_pc`=0,1,2,3 on consecutive cycles with matching `if_instruction` and `if_valid`=1.
- **Stall:** `stall`=1 for 3 cycles at PC=2 → `instr_mem_addr` stays 2 and `if_pc`/`if_instruction` hold. Release → fetch resumes at 2 with no skipped or duplicated word.
- **Branch:** `branch_taken`=1 with `branch_target`=10 at PC=3 → next cycle `if_valid`=0 and `instr_mem_addr`=10; the cycle after, `if_pc`=10 and `if_valid`=1. Repeat with `stall`=1 asserted in the same cycle → same result.
- **Halt:** `HALT_WORD` at address 5 → `halted`=1, `instr_mem_en`=0, `if_valid`=0, PC=5. A following branch is ignored; only reset recovers.
- **Wrap-around:** `ADDR_WIDTH`=4, start at 14 → `if_pc` sequence 14, 15, 0, 1.
